// File: rtl/ir_switch_pkg.sv
// Shared types and constants for the IR remote switch controller.
// No logic, no latency, no backpressure.
package ir_switch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COUNT   = 2'd1,
      ST_EXEC    = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_t;

   typedef logic [2:0] pcnt_t;

   localparam pcnt_t CMD_NEXT   = 3'd1;
   localparam pcnt_t CMD_TOGGLE = 3'd2;
   localparam pcnt_t CMD_OFF    = 3'd3;
   localparam pcnt_t PCNT_MAX   = 3'd7;

   function automatic logic [3:0] rotl4(input logic [3:0] v);
      return {v[2:0], v[3]};
   endfunction

endpackage

// File: rtl/rxd_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detector for the IR line.
// rise appears 3 cycles after an rxd 0->1 transition; no backpressure.
module rxd_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic rxd,
   output logic rise
);

   logic sync1_q,  sync1_d;
   logic rxd_s_q,  rxd_s_d;
   logic rxd_old_q, rxd_old_d;
   logic rise_q,   rise_d;

   always_comb begin
      sync1_d   = rxd;
      rxd_s_d   = sync1_q;
      rxd_old_d = rxd_s_q;
      rise_d    = rxd_s_q & ~rxd_old_q;
   end

   // Line idles high, so the chain resets to 1 to avoid a spurious edge on release.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q   <= 1'b1;
         rxd_s_q   <= 1'b1;
         rxd_old_q <= 1'b1;
         rise_q    <= 1'b0;
      end else begin
         sync1_q   <= sync1_d;
         rxd_s_q   <= rxd_s_d;
         rxd_old_q <= rxd_old_d;
         rise_q    <= rise_d;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/ir_switch_ctrl.sv
// Counts IR pulses per burst and applies channel-next / power-toggle / off commands.
// Command takes effect GAP_CYCLES+2 cycles after the last rise; input ignored while busy.
module ir_switch_ctrl
   import ir_switch_pkg::*;
#(
   parameter int GAP_CYCLES     = 1200000,
   parameter int LOCKOUT_CYCLES = 12000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic [3:0] led,
   output logic       power,
   output logic       busy,
   output logic       cmd_err,
   output logic       sd,
   output logic       txd
);

   localparam int GAP_W = $clog2(GAP_CYCLES);
   localparam int LK_W  = $clog2(LOCKOUT_CYCLES);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
   localparam logic [LK_W-1:0]  LK_LAST  = LK_W'(LOCKOUT_CYCLES - 1);

   logic rise;

   state_t           state_q,   state_d;
   pcnt_t            pcnt_q,    pcnt_d;
   logic [GAP_W-1:0] gap_q,     gap_d;
   logic [LK_W-1:0]  lk_q,      lk_d;
   logic [3:0]       led_q,     led_d;
   logic             power_q,   power_d;
   logic             cmd_err_q, cmd_err_d;

   rxd_edge_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .rxd   (rxd),
      .rise  (rise)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pcnt_q    <= '0;
         gap_q     <= '0;
         lk_q      <= '0;
         led_q     <= 4'b0001;
         power_q   <= 1'b0;
         cmd_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pcnt_q    <= pcnt_d;
         gap_q     <= gap_d;
         lk_q      <= lk_d;
         led_q     <= led_d;
         power_q   <= power_d;
         cmd_err_q <= cmd_err_d;
      end
   end

   // Counters are cleared on every exit so they never run past their terminal value.
   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      gap_d   = gap_q;
      lk_d    = lk_q;
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               state_d = ST_COUNT;
               pcnt_d  = 3'd1;
               gap_d   = '0;
            end
         end
         ST_COUNT: begin
            if (rise) begin
               gap_d = '0;
               if (pcnt_q != PCNT_MAX) begin
                  pcnt_d = pcnt_q + 3'd1;
               end
            end else if (gap_q == GAP_LAST) begin
               state_d = ST_EXEC;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         ST_EXEC: begin
            state_d = ST_LOCKOUT;
            lk_d    = '0;
         end
         ST_LOCKOUT: begin
            if (lk_q == LK_LAST) begin
               state_d = ST_IDLE;
               lk_d    = '0;
            end else begin
               lk_d = lk_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      led_d     = led_q;
      power_d   = power_q;
      cmd_err_d = 1'b0;
      if (state_q == ST_EXEC) begin
         case (pcnt_q)
            CMD_NEXT:   led_d   = rotl4(led_q);
            CMD_TOGGLE: power_d = ~power_q;
            CMD_OFF: begin
               power_d = 1'b0;
               led_d   = 4'b0001;
            end
            default:    cmd_err_d = (pcnt_q >= 3'd4);
         endcase
      end
   end

   assign led     = led_q;
   assign power   = power_q;
   assign busy    = (state_q != ST_IDLE);
   assign cmd_err = cmd_err_q;
   assign sd      = 1'b0;
   assign txd     = 1'b0;

endmodule
